insn_encoder: RTL and testbench



---
 rtl/insn_encoder.sv | 190 +++++++++++++++++++
 tb/tb_insn_encoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder.sv
// insn_encoder
//
// Turns RV32I field sets (lw, sw, and, or, add, sub) into 32-bit instruction words and writes
// them in order into instruction memory, starting at word address 0.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   clear              restart fill at address 0, flush buffer, clear flags
//   in_valid/in_ready  field-set handshake (transfer when both high)
//   in_op              0=lw 1=sw 2=and 3=or 4=add 5=sub, 6/7 illegal
//   in_rd/rs1/rs2      register indices
//   in_imm             12-bit signed offset (lw/sw only)
//   imem_we            write strobe (buffer non-empty)
//   imem_ready         memory accepts the write this cycle
//   imem_addr          word address (number of words already written)
//   imem_wdata         encoded word at the buffer head
//   full               DEPTH words have been written
//   err_illegal        sticky: an illegal op was accepted
//
// Configuration macro INSN_ENCODER_ILLEGAL_NOP_EN:
//   defined   -> illegal ops are written as NOP (0x00000013)
//   undefined -> illegal ops complete the handshake but are dropped
// err_illegal is set in both cases.
//
// DEPTH must not exceed 2**ADDR_W.

module insn_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [6:0]  OpcLoad  = 7'b0000011;
  localparam logic [6:0]  OpcStore = 7'b0100011;
  localparam logic [6:0]  OpcReg   = 7'b0110011;
  localparam logic [31:0] NopWord  = 32'h0000_0013;

  // The fill counter needs one extra bit so it can hold DEPTH itself.
  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DepthSum = (ADDR_W + 2)'(DEPTH);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [31:0]     bufQ [2];
  logic [31:0]     bufD [2];
  logic            rdPtrQ, rdPtrD;
  logic            wrPtrQ, wrPtrD;
  logic [1:0]      occQ, occD;
  logic [ADDR_W:0] countQ, countD;
  logic            errQ, errD;

  // ---------------------------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------------------------
  logic [31:0] encWord;
  logic        encLegal;

  always_comb begin
    encWord  = NopWord;
    encLegal = 1'b1;
    case (in_op)
      3'd0:    encWord = {in_imm, in_rs1, 3'b010, in_rd, OpcLoad};
      3'd1:    encWord = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OpcStore};
      3'd2:    encWord = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OpcReg};
      3'd3:    encWord = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OpcReg};
      3'd4:    encWord = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OpcReg};
      3'd5:    encWord = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OpcReg};
      default: begin
        encWord  = NopWord;
        encLegal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Handshake and write-port control
  // ---------------------------------------------------------------------------------------------
  logic              flush;
  logic              notEmpty;
  logic [ADDR_W+1:0] fillSum;
  logic              accept;
  logic              pushEn;
  logic              popEn;

  assign flush    = !rst_n || clear;
  assign notEmpty = (occQ != 2'd0);

  // Words already written plus words still buffered; admission stops once this reaches DEPTH
  // so the memory can never be overrun.
  assign fillSum  = {1'b0, countQ} + {{ADDR_W{1'b0}}, occQ};

  assign in_ready = !flush && (occQ < 2'd2) && (fillSum < DepthSum);
  assign accept   = in_valid && in_ready;

`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
  assign pushEn   = accept;
`else
  assign pushEn   = accept && encLegal;
`endif

  // No write may retire in a clear/reset cycle even if the buffer still holds words.
  assign imem_we     = !flush && notEmpty;
  assign popEn       = imem_we && imem_ready;

  assign imem_addr   = countQ[ADDR_W-1:0];
  assign imem_wdata  = notEmpty ? bufQ[rdPtrQ] : 32'h0;
  assign full        = (countQ == DepthCnt);
  assign err_illegal = errQ;

  // ---------------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    bufD   = bufQ;
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;
    occD   = occQ;
    countD = countQ;
    errD   = errQ;

    if (clear) begin
      rdPtrD = 1'b0;
      wrPtrD = 1'b0;
      occD   = 2'd0;
      countD = '0;
      errD   = 1'b0;
    end else begin
      if (popEn) begin
        rdPtrD = ~rdPtrQ;
        countD = countQ + 1'b1;
      end

      if (pushEn) begin
        bufD[wrPtrQ] = encWord;
        wrPtrD       = ~wrPtrQ;
      end

      // Push and pop together leave occupancy unchanged; pointers keep the order.
      case ({pushEn, popEn})
        2'b10:   occD = occQ + 2'd1;
        2'b01:   occD = occQ - 2'd1;
        default: occD = occQ;
      endcase

      if (accept && !encLegal) begin
        errD = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Registers (synchronous reset)
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bufQ[0] <= 32'h0;
      bufQ[1] <= 32'h0;
      rdPtrQ  <= 1'b0;
      wrPtrQ  <= 1'b0;
      occQ    <= 2'd0;
      countQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      bufQ    <= bufD;
      rdPtrQ  <= rdPtrD;
      wrPtrQ  <= wrPtrD;
      occQ    <= occD;
      countQ  <= countD;
      errQ    <= errD;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a behavioural model of the fill/buffer rules.
module tb_insn_encoder;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [11:0]   in_imm;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          full;
  logic          err_illegal;

  always #5 clk = ~clk;

  insn_encoder #(
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .full       (full),
    .err_illegal(err_illegal)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sbQ[$];    // expected writes still to come
  wr_t wrLog[$];  // writes actually retired by the DUT

  int checks  = 0;
  int errors  = 0;
  int retired = 0;
  bit mErr    = 1'b0;
  bit monEn   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Instruction word from the ISA field layout, built with plain arithmetic.
  function automatic logic [31:0] refEncode(input int unsigned op, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input int unsigned imm);
    int unsigned w;
    int unsigned f3;
    int unsigned f7;
    f3 = 0;
    f7 = 0;
    case (op)
      0: w = imm * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + 3;
      1: w = (imm / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12)
             + (imm % 32) * (1 << 7) + 35;
      2, 3, 4, 5: begin
        if (op == 2) f3 = 7;
        if (op == 3) f3 = 6;
        if (op == 5) f7 = 32;
        w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
            + rd * (1 << 7) + 51;
      end
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  // -----------------------------------------------------------------------------------------------
  // Model + monitor: at each falling edge compare the DUT with the model, then advance the model
  // to what the coming rising edge should do.
  // -----------------------------------------------------------------------------------------------
  bit          mClr;
  bit          mReady;
  bit          mWe;
  int          mPend;
  int          pushAddr;
  logic [31:0] mWord;
  wr_t         ent;

  always @(negedge clk) begin
    if (monEn) begin
      mClr   = !rst_n || clear;
      mPend  = sbQ.size();
      mReady = !mClr && (mPend < 2) && ((retired + mPend) < DEPTH);
      mWe    = !mClr && (mPend > 0);

      check("in_ready", 32'(in_ready), 32'(mReady));
      check("imem_we", 32'(imem_we), 32'(mWe));
      check("full", 32'(full), 32'(retired == DEPTH));
      check("err_illegal", 32'(err_illegal), 32'(mErr));
      if (mPend == 0 && retired == 0) begin
        check("idle addr", 32'(imem_addr), 32'h0);
        check("idle wdata", imem_wdata, 32'h0);
      end
      if (mWe && imem_we) begin
        check("write addr", 32'(imem_addr), 32'(sbQ[0].addr));
        check("write data", imem_wdata, sbQ[0].data);
      end

      if (mClr) begin
        sbQ.delete();
        retired = 0;
        mErr    = 1'b0;
      end else begin
        pushAddr = retired + mPend;
        if (mWe && imem_ready) begin
          ent.addr = imem_addr;
          ent.data = imem_wdata;
          wrLog.push_back(ent);
          void'(sbQ.pop_front());
          retired++;
        end
        if (in_valid && mReady) begin
          mWord = refEncode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm));
          ent.addr = AW'(pushAddr);
          ent.data = mWord;
          if (in_op > 3'd5) begin
            mErr = 1'b1;
`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
            sbQ.push_back(ent);
`endif
          end else begin
            sbQ.push_back(ent);
          end
        end
      end
    end
  end

  // -----------------------------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // -----------------------------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm,
                      input int budget, output bit ok);
    in_op    = 3'(op);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = 12'(imm);
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic put(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit ok;
    send(op, rd, rs1, rs2, imm, 20, ok);
    check("accept within budget", 32'(ok), 32'h1);
  endtask

  task automatic doClear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    wrLog.delete();
  endtask

  // -----------------------------------------------------------------------------------------------
  // Stimulus
  // -----------------------------------------------------------------------------------------------
  logic [31:0] encExp [6];
  int          nAcc;
  bit          ok;

  initial begin
    encExp[0] = 32'h002081B3;
    encExp[1] = 32'h407302B3;
    encExp[2] = 32'h0020F233;
    encExp[3] = 32'h0020E233;
    encExp[4] = 32'h00812083;
    encExp[5] = 32'hFE312E23;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0; imem_ready = 1'b0;
    cyc(1);
    monEn = 1'b1;
    cyc(1);
    rst_n = 1'b1;

    // Encodings; unused fields carry junk that must be ignored.
    imem_ready = 1'b1;
    put(4, 3, 1, 2, int'($urandom_range(0, 4095)));
    put(5, 5, 6, 7, int'($urandom_range(0, 4095)));
    put(2, 4, 1, 2, int'($urandom_range(0, 4095)));
    put(3, 4, 1, 2, int'($urandom_range(0, 4095)));
    put(0, 1, 2, int'($urandom_range(0, 31)), 8);
    put(1, int'($urandom_range(0, 31)), 2, 3, 12'hFFC);
    cyc(3);
    check("enc count", 32'(wrLog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wrLog.size(); i++) begin
      check("enc addr", 32'(wrLog[i].addr), 32'(i));
      check("enc word", wrLog[i].data, encExp[i]);
    end
    check("full after DEPTH writes", 32'(full), 32'h1);

    // Backpressure: memory stalled, source always valid.
    doClear();
    imem_ready = 1'b0;
    in_valid   = 1'b1;
    nAcc       = 0;
    for (int i = 0; i < 5; i++) begin
      in_op  = 3'($urandom_range(0, 5));
      in_rd  = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      in_imm = 12'($urandom);
      @(negedge clk);
      if (in_ready) nAcc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp in_ready low", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp accepts", 32'(nAcc), 32'd2);
    imem_ready = 1'b1;
    cyc(4);
    check("bp writes", 32'(wrLog.size()), 32'd2);
    for (int i = 0; i < 2 && i < wrLog.size(); i++) begin
      check("bp addr", 32'(wrLog[i].addr), 32'(i));
    end

    // Full: stream more adds than the memory holds.
    doClear();
    nAcc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(4, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), 0, 3, ok);
      if (ok) nAcc++;
    end
    cyc(2);
    check("full accepts", 32'(nAcc), 32'(DEPTH));
    check("full writes", 32'(wrLog.size()), 32'(DEPTH));
    if (wrLog.size() > 0) check("full last addr", 32'(wrLog[wrLog.size() - 1].addr),
                                32'(DEPTH - 1));
    check("full flag", 32'(full), 32'h1);
    check("full in_ready", 32'(in_ready), 32'h0);

    // Illegal op followed by add x3,x1,x2.
    doClear();
    put(7, 1, 1, 1, 1);
    put(4, 3, 1, 2, 0);
    cyc(3);
`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
    check("illegal writes", 32'(wrLog.size()), 32'd2);
    if (wrLog.size() == 2) begin
      check("illegal nop", wrLog[0].data, 32'h00000013);
      check("illegal nop addr", 32'(wrLog[0].addr), 32'h0);
      check("illegal add", wrLog[1].data, 32'h002081B3);
      check("illegal add addr", 32'(wrLog[1].addr), 32'h1);
    end
`else
    check("illegal writes", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() == 1) begin
      check("illegal add", wrLog[0].data, 32'h002081B3);
      check("illegal add addr", 32'(wrLog[0].addr), 32'h0);
    end
`endif
    check("illegal flag", 32'(err_illegal), 32'h1);

    // Clear (k=0) and reset (k=1) with a word pending and the source valid.
    for (int k = 0; k < 2; k++) begin
      doClear();
      put(6, 0, 0, 0, 0);
      cyc(2);
      imem_ready = 1'b0;
      put(4, 9, 10, 11, 0);
      in_valid   = 1'b1;
      in_op      = 3'd4;
      imem_ready = 1'b1;
      if (k == 0) clear = 1'b1;
      else rst_n = 1'b0;
      @(negedge clk);
      check("flush in_ready", 32'(in_ready), 32'h0);
      check("flush imem_we", 32'(imem_we), 32'h0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      wrLog.delete();
      put(5, 5, 6, 7, 0);
      cyc(3);
      check("flush writes", 32'(wrLog.size()), 32'd1);
      if (wrLog.size() == 1) begin
        check("flush addr", 32'(wrLog[0].addr), 32'h0);
        check("flush word", wrLog[0].data, 32'h407302B3);
      end
      check("flush full", 32'(full), 32'h0);
      check("flush err", 32'(err_illegal), 32'h0);
    end

    // Randomized traffic; the model and monitor do the checking.
    doClear();
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                               : 3'($urandom_range(0, 5));
      in_rd      = 5'($urandom);
      in_rs1     = 5'($urandom);
      in_rs2     = 5'($urandom);
      in_imm     = 12'($urandom);
      imem_ready = ($urandom_range(0, 2) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      rst_n      = ($urandom_range(0, 96) != 0);
      cyc(1);
    end
    in_valid   = 1'b0;
    clear      = 1'b0;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
